result_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter between the calculator FSM and the OLED/seven-segment display drivers. It takes a 20-bit operand or result word and produces packed BCD digits, a sign flag and a significant-digit count for leading-zero blanking. It uses an iterative double-dabble engine with a start/busy/done handshake, one shift per clock.

---
 rtl/calc_pkg.sv | 11 +
 rtl/result_bcd_converter_if.sv | 30 +++
 rtl/bcd_dabble_step.sv | 21 ++
 rtl/result_bcd_converter.sv | 100 ++++++++++
 tb/tb_result_bcd_converter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator constants and the converter FSM state encoding.
package calc_pkg;
  localparam int CALC_IN_W   = 20;
  localparam int CALC_DIGITS = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;
endpackage

// File: rtl/result_bcd_converter_if.sv
// Start/busy/done conversion port bundle between the calculator FSM and the BCD converter.
interface result_bcd_converter_if
  import calc_pkg::*;
#(
  parameter int IN_W   = CALC_IN_W,
  parameter int DIGITS = CALC_DIGITS
);
  // Handshake: start is sampled only while idle (busy=0); value and signed_mode are
  // captured on that edge. busy stays high until done, a one-cycle pulse from which
  // bcd/negative/num_digits are valid and held until the next done.
  logic                  start;
  logic [IN_W-1:0]       value;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negative;
  logic [2:0]            num_digits;
  state_t                state;

  modport master (
    output start, value, signed_mode,
    input  busy, done, bcd, negative, num_digits, state
  );

  modport slave (
    input  start, value, signed_mode,
    output busy, done, bcd, negative, num_digits, state
  );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift left by one bit.
module bcd_dabble_step #(
  parameter int DIGITS = 7
) (
   input  logic [4*DIGITS-1:0] scratch,
   input  logic                shift_in,
   output logic [4*DIGITS-1:0] next_scratch
);

   logic [4*DIGITS-1:0] adjusted;

   always_comb begin
      adjusted = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      next_scratch = {adjusted[4*DIGITS-2:0], shift_in};
   end

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter with sign handling and significant-digit count.
module result_bcd_converter
   import calc_pkg::*;
#(
   parameter int IN_W   = CALC_IN_W,
   parameter int DIGITS = CALC_DIGITS
) (
   input  logic             clk,
   input  logic             reset,
   result_bcd_converter_if.slave bus
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BW    = 4 * DIGITS;

   state_t              state;
   logic [BW-1:0]       scratch;
   logic [BW-1:0]       scratch_next;
   logic [IN_W-1:0]     magnitude;
   logic [CNT_W-1:0]    count;
   logic                neg_pending;
   logic                busy;
   logic                done;
   logic [BW-1:0]       bcd;
   logic                negative;
   logic [2:0]          num_digits;
   logic [2:0]          nd_next;
   logic                take_neg;

   bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
      .scratch      (scratch),
      .shift_in     (magnitude[IN_W-1]),
      .next_scratch (scratch_next)
   );

   assign take_neg = bus.signed_mode & bus.value[IN_W-1];

   // Highest nonzero digit wins; an all-zero result still shows one digit.
   always_comb begin
      nd_next = 3'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] != 4'd0)
            nd_next = 3'(i + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         scratch     <= '0;
         magnitude   <= '0;
         count       <= '0;
         neg_pending <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         bcd         <= '0;
         negative    <= 1'b0;
         num_digits  <= 3'd1;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  // -0x80000 wraps to itself, which is the correct 524288 magnitude.
                  magnitude   <= take_neg ? -bus.value : bus.value;
                  neg_pending <= take_neg;
                  scratch     <= '0;
                  count       <= CNT_W'(IN_W);
                  busy        <= 1'b1;
                  state       <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scratch   <= scratch_next;
               magnitude <= magnitude << 1;
               count     <= count - CNT_W'(1);
               if (count == CNT_W'(1))
                  state <= ST_FINISH;
            end
            ST_FINISH: begin
               bcd        <= scratch;
               negative   <= neg_pending;
               num_digits <= nd_next;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.bcd        = bcd;
   assign bus.negative   = negative;
   assign bus.num_digits = num_digits;
   assign bus.state      = state;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: arithmetic reference model plus directed vectors.
module tb_result_bcd_converter;
   import calc_pkg::*;

   localparam int IN_W = CALC_IN_W;
   localparam int DIGITS = CALC_DIGITS;
   localparam int BW = 4 * DIGITS;
   localparam int LAT = IN_W + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;

   result_bcd_converter_if bus ();

   result_bcd_converter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: expected outputs after each edge.
   logic [31:0]   exp_q[$];
   bit            m_valid = 1'b0;
   bit            m_busy = 1'b0;
   bit            m_done = 1'b0;
   int            m_left = 0;
   logic [BW-1:0] m_bcd = '0;
   logic          m_neg = 1'b0;
   logic [2:0]    m_nd = 3'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Packs {negative, num_digits, bcd} from plain decimal arithmetic.
   function automatic logic [31:0] model_convert(input logic [IN_W-1:0] v, input logic sm);
      int unsigned   mag;
      bit            neg;
      logic [BW-1:0] b;
      int            nd;
      neg = sm && v[IN_W-1];
      mag = 32'(v);
      if (neg) mag = (32'd1 << IN_W) - mag;
      b = '0;
      nd = 0;
      do begin
         b[4*nd +: 4] = 4'(mag % 10);
         mag = mag / 10;
         nd++;
      end while (mag != 0);
      return {neg, 3'(nd), b};
   endfunction

   always @(posedge clk) begin
      m_valid <= 1'b1;
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_bcd  <= '0;
         m_neg  <= 1'b0;
         m_nd   <= 3'd1;
         exp_q.delete();
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               {m_neg, m_nd, m_bcd} <= exp_q.pop_front();
            end else begin
               m_left <= m_left - 1;
            end
         end else if (bus.start) begin
            m_busy <= 1'b1;
            m_left <= LAT;
            exp_q.push_back(model_convert(bus.value, bus.signed_mode));
         end
      end
   end

   // Every cycle: handshake timing and held outputs must match the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("bcd", 32'(bus.bcd), 32'(m_bcd));
         chk("negative", 32'(bus.negative), 32'(m_neg));
         chk("num_digits", 32'(bus.num_digits), 32'(m_nd));
      end
   end

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_start(input logic [IN_W-1:0] v, input logic sm);
      bus.start       = 1'b1;
      bus.value       = v;
      bus.signed_mode = sm;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int k);
      bit got;
      k = 0;
      got = 1'b0;
      while (!got && k < limit) begin
         @(negedge clk);
         k++;
         got = bus.done;
      end
      chk("done_seen", 32'(got), 32'd1);
   endtask

   task automatic chk_out(input string tag, input logic [BW-1:0] b, input logic n, input logic [2:0] nd);
      chk({tag, "_bcd"}, 32'(bus.bcd), 32'(b));
      chk({tag, "_neg"}, 32'(bus.negative), 32'(n));
      chk({tag, "_nd"}, 32'(bus.num_digits), 32'(nd));
   endtask

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int k;
      int n;
      int dones;
      bus.start       = 1'b0;
      bus.value       = '0;
      bus.signed_mode = 1'b0;

      apply_reset(3);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk_out("rst", '0, 1'b0, 3'd1);

      do_start(20'd0, 1'b0);
      wait_done(40, k);
      chk("lat_zero", 32'(k), 32'd21);
      chk_out("zero", '0, 1'b0, 3'd1);

      do_start(20'hFFFFF, 1'b0);
      wait_done(40, k);
      chk_out("max_u", 28'h1048575, 1'b0, 3'd7);

      do_start(20'hFFFFF, 1'b1);
      wait_done(40, k);
      chk_out("minus1", 28'h0000001, 1'b1, 3'd1);

      do_start(20'h80000, 1'b1);
      wait_done(40, k);
      chk_out("most_neg", 28'h0524288, 1'b1, 3'd6);

      do_start(20'd0, 1'b1);
      wait_done(40, k);
      chk_out("signed_zero", '0, 1'b0, 3'd1);

      // Starts during busy are ignored; value changes after acceptance are harmless.
      do_start(20'd12345, 1'b0);
      n = 0;
      dones = 0;
      while (dones == 0 && n < 40) begin
         bus.start = (n == 4 || n == 9);
         bus.value = 20'd555;
         @(negedge clk);
         n++;
         if (bus.done) dones++;
      end
      chk("ignore_lat", 32'(n), 32'd21);
      chk_out("ignore", 28'h0012345, 1'b0, 3'd5);

      bus.start = 1'b1;
      bus.value = 20'd99;
      bus.signed_mode = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(40, k);
      chk("b2b_gap", 32'(k + 1), 32'd22);
      chk_out("b2b", 28'h0000099, 1'b0, 3'd2);

      // Abort mid-conversion.
      do_start(20'd54321, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_dones", 32'(dones), 32'd0);
      chk_out("abort", '0, 1'b0, 3'd1);

      do_start(20'd7, 1'b0);
      wait_done(40, k);
      chk_out("after_abort", 28'h0000007, 1'b0, 3'd1);

      for (int i = 0; i < 500; i++) begin
         do_start(20'($urandom_range(0, 20'hFFFFF)), 1'($urandom_range(0, 1)));
         wait_done(40, k);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
